// File: rtl/ndp_result_writeback.sv
// ndp_result_writeback
// AHB-Lite write master that streams the NDP result vector out_c to DRAM.
// Two WIDTH-bit elements are packed per 32-bit word, word w = {elem[2w+1], elem[2w]},
// and written with back-to-back INCR16 bursts starting at a 64-byte aligned base.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   start             one-cycle pulse, accepted only when idle
//   dest_addr         DRAM base byte address, low 6 bits ignored
//   out_c             result vector, held stable by the core while busy
//   busy/done/error   status: busy while transferring, done pulse, sticky error
//   HADDR..HWDATA     AHB-Lite master outputs
//   HREADY, HRESP     AHB-Lite slave response
//
// Optional feature (macro NDP_WB_CHECKSUM_EN): adds output checksum[31:0], a
// rotate-xor over every word whose data phase completed OKAY.
module ndp_result_writeback #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned NUM_ELEM  = 1024,
    parameter int unsigned BURST_LEN = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [31:0]               dest_addr,
    input  logic [NUM_ELEM*WIDTH-1:0] out_c,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [31:0]               HADDR,
    output logic [1:0]                HTRANS,
    output logic                      HWRITE,
    output logic [2:0]                HSIZE,
    output logic [2:0]                HBURST,
    output logic [3:0]                HPROT,
    output logic [31:0]               HWDATA,
    input  logic                      HREADY,
    input  logic                      HRESP
`ifdef NDP_WB_CHECKSUM_EN
    ,
    output logic [31:0]               checksum
`endif
);

    localparam int unsigned NumWords = NUM_ELEM / 2;
    localparam int unsigned WIdxW    = $clog2(NumWords);
    localparam int unsigned BIdxW    = $clog2(BURST_LEN);

    typedef enum logic [2:0] {StIdle, StAddr, StLastData, StErr, StDone} state_e;

    state_e            state_q, state_d;
    logic [31:0]       base_q;
    logic [WIdxW-1:0]  w_q;       // index of the beat whose address phase is on the bus
    logic              error_q;
    logic [WIdxW-1:0]  data_idx;
    logic [31:0]       cur_word;
    logic              start_ok;
    logic              data_phase;
    logic              data_err;
    logic              last_addr;

    assign start_ok   = (state_q == StIdle) && start;
    // Data phase belongs to the previous beat; w_q wraps to 0 after the last address.
    assign data_idx   = w_q - WIdxW'(1);
    assign cur_word   = out_c[{data_idx, 5'b00000} +: 32];
    assign data_phase = ((state_q == StAddr) && (w_q != '0)) || (state_q == StLastData);
    // First cycle of a two-cycle ERROR response.
    assign data_err   = data_phase && HRESP && !HREADY;
    assign last_addr  = (w_q == WIdxW'(NumWords - 1));

    assign HSIZE = 3'b010;
    assign HPROT = 4'b0011;
    assign error = error_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (start) state_d = StAddr;
            StAddr: begin
                if (data_err)                    state_d = StErr;
                else if (HREADY && last_addr)    state_d = StLastData;
            end
            StLastData: begin
                if (data_err)    state_d = StErr;
                else if (HREADY) state_d = StDone;
            end
            StErr:      if (HREADY) state_d = StDone;
            StDone:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q  <= '0;
            w_q     <= '0;
            error_q <= 1'b0;
        end else begin
            if (start_ok) begin
                base_q  <= dest_addr & 32'hFFFF_FFC0;
                w_q     <= '0;
                error_q <= 1'b0;
            end else if (state_q == StAddr && HREADY) begin
                w_q <= w_q + WIdxW'(1);
            end
            if (data_err) begin
                error_q <= 1'b1;
            end
        end
    end

`ifdef NDP_WB_CHECKSUM_EN
    logic [31:0] checksum_q;
    logic        data_ok;

    assign data_ok  = data_phase && HREADY && !HRESP;
    assign checksum = checksum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= '0;
        end else if (start_ok) begin
            checksum_q <= '0;
        end else if (data_ok) begin
            checksum_q <= {checksum_q[30:0], checksum_q[31]} ^ cur_word;
        end
    end
`endif

    // Output logic
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        HADDR  = '0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HBURST = 3'b000;
        HWDATA = '0;
        case (state_q)
            StAddr: begin
                busy   = 1'b1;
                HADDR  = base_q + {{(30 - WIdxW){1'b0}}, w_q, 2'b00};
                HTRANS = (w_q[BIdxW-1:0] == '0) ? 2'b10 : 2'b11;
                HWRITE = 1'b1;
                HBURST = 3'b111;
                HWDATA = (w_q != '0) ? cur_word : 32'h0;
            end
            StLastData: begin
                busy   = 1'b1;
                HWDATA = cur_word;
            end
            StErr: begin
                busy   = 1'b1;
                HWDATA = cur_word;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

endmodule
